// File: rtl/spec_pkt_write_ctrl.sv
// Write-side packet sequencer: pushes words speculatively into the FIFO, then
// commits whole good packets or rolls back bad/oversized/truncated ones.
module spec_pkt_write_ctrl #(
    parameter int ASIZE  = 4,
    parameter int DWIDTH = 64
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic              in_abort,
    input  logic              wfull,
    output logic              winc,
    output logic [DWIDTH-1:0] wdata,
    output logic              inc_wptr,
    output logic              dec_wptr,
    output logic [ASIZE:0]    inc_dec_value,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       drop_cnt
);

    localparam logic [ASIZE:0] DEPTH_V = (ASIZE+1)'(1 << ASIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_COMMIT,
        S_ROLLBACK,
        S_DROP
    } state_t;

    state_t         r_state, w_next;
    logic [ASIZE:0] r_cnt, w_cnt_next;
    logic           r_ovf, w_ovf_next;
    logic [15:0]    r_pkt_cnt, r_drop_cnt;
    logic           w_ready, w_winc, w_inc, w_dec;
    logic [ASIZE:0] w_val;
    logic           w_pkt_inc, w_drop_inc;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_ovf_next = r_ovf;
        w_ready    = 1'b0;
        w_winc     = 1'b0;
        w_inc      = 1'b0;
        w_dec      = 1'b0;
        w_val      = '0;
        w_pkt_inc  = 1'b0;
        w_drop_inc = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ready = ~wfull;
                if (in_valid && w_ready) begin
                    if (in_sop) begin
                        w_winc     = 1'b1;
                        w_cnt_next = (ASIZE+1)'(1);
                        w_ovf_next = 1'b0;
                        if (in_eop) w_next = in_abort ? S_ROLLBACK : S_COMMIT;
                        else        w_next = S_WRITE;
                    end else begin
                        w_drop_inc = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                w_ready = ~wfull & ~in_sop & (r_cnt != DEPTH_V);
                if (in_valid && w_ready) begin
                    w_winc     = 1'b1;
                    w_cnt_next = r_cnt + 1'b1;
                    if (in_eop) w_next = in_abort ? S_ROLLBACK : S_COMMIT;
                end else if (in_valid && in_sop) begin
                    // Truncated packet: leave the sop word for IDLE to pick up.
                    w_next     = S_ROLLBACK;
                    w_ovf_next = 1'b0;
                end else if (in_valid && (r_cnt == DEPTH_V)) begin
                    w_next     = S_ROLLBACK;
                    w_ovf_next = 1'b1;
                end
            end
            S_COMMIT: begin
                w_inc      = 1'b1;
                w_val      = r_cnt;
                w_pkt_inc  = 1'b1;
                w_cnt_next = '0;
                w_next     = S_IDLE;
            end
            S_ROLLBACK: begin
                w_dec      = 1'b1;
                w_val      = r_cnt;
                w_drop_inc = 1'b1;
                w_cnt_next = '0;
                w_ovf_next = 1'b0;
                w_next     = r_ovf ? S_DROP : S_IDLE;
            end
            S_DROP: begin
                // Oversized packet tail is swallowed without touching the FIFO.
                w_ready = 1'b1;
                if (in_valid && in_eop) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_ovf   <= w_ovf_next;
            if (w_pkt_inc && (r_pkt_cnt != 16'hFFFF))
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            if (w_drop_inc && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign in_ready      = w_ready;
    assign winc          = w_winc;
    assign wdata         = in_data;
    assign inc_wptr      = w_inc;
    assign dec_wptr      = w_dec;
    assign inc_dec_value = w_val;
    assign pkt_cnt       = r_pkt_cnt;
    assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_spec_pkt_write_ctrl.sv
// Directed bench for spec_pkt_write_ctrl with a small FIFO occupancy model driving wfull.
module tb_spec_pkt_write_ctrl;

    localparam int ASIZE  = 4;
    localparam int DWIDTH = 64;
    localparam int DEPTH  = 1 << ASIZE;

    logic              wclk;
    logic              wrst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] in_data;
    logic              in_sop;
    logic              in_eop;
    logic              in_abort;
    logic              wfull;
    logic              winc;
    logic [DWIDTH-1:0] wdata;
    logic              inc_wptr;
    logic              dec_wptr;
    logic [ASIZE:0]    inc_dec_value;
    logic [15:0]       pkt_cnt;
    logic [15:0]       drop_cnt;

    spec_pkt_write_ctrl #(.ASIZE(ASIZE), .DWIDTH(DWIDTH)) dut (
        .wclk(wclk), .wrst_n(wrst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_abort(in_abort),
        .wfull(wfull), .winc(winc), .wdata(wdata),
        .inc_wptr(inc_wptr), .dec_wptr(dec_wptr), .inc_dec_value(inc_dec_value),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // FIFO environment: words in flight (speculative + committed), reader pops via rd.
    int   occ;
    logic rd;
    assign wfull = (occ >= DEPTH);

    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) occ <= 0;
        else occ <= occ + (winc ? 1 : 0) - (dec_wptr ? int'(inc_dec_value) : 0)
                        - ((rd && occ != 0) ? 1 : 0);
    end

    int n_winc = 0, n_inc = 0, n_dec = 0, n_skip = 0;
    int last_inc_val = 0, last_dec_val = 0;
    logic [63:0] wq[$];

    always @(negedge wclk) begin
        if (winc) begin
            n_winc++;
            wq.push_back(wdata);
        end
        if (in_valid && in_ready && !winc) n_skip++;
        if (inc_wptr) begin n_inc++; last_inc_val = int'(inc_dec_value); end
        if (dec_wptr) begin n_dec++; last_dec_val = int'(inc_dec_value); end
        if (inc_wptr || dec_wptr) begin
            check("inv_winc_vs_ptr", winc, 1'b0);
            check("inv_inc_and_dec", inc_wptr & dec_wptr, 1'b0);
            check("inv_value_range",
                  (inc_dec_value >= 1 && inc_dec_value <= DEPTH), 1'b1);
        end
    end

    int b_winc, b_inc, b_dec, b_skip;
    task automatic snap();
        b_winc = n_winc; b_inc = n_inc; b_dec = n_dec; b_skip = n_skip;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge wclk); #1; end
    endtask

    task automatic word(input logic [63:0] d, input logic s, input logic e, input logic a);
        int  n = 0;
        bit  done = 0;
        in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; in_abort = a;
        while (!done) begin
            @(negedge wclk);
            if (in_ready) done = 1;
            @(posedge wclk); #1;
            n++;
            if (!done && n > 50) begin
                check("accept_timeout", in_ready, 1'b1);
                done = 1;
            end
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_abort = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rd = 1'b1;
        while (occ != 0 && n < 40) begin cyc(1); n++; end
        rd = 1'b0;
        check("drain_empty", occ, 0);
    endtask

    initial begin
        wrst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sop = 1'b0;
        in_eop = 1'b0; in_abort = 1'b0; rd = 1'b0;

        // Reset state
        @(negedge wclk);
        check("rst_winc", winc, 0);
        check("rst_inc", inc_wptr, 0);
        check("rst_dec", dec_wptr, 0);
        check("rst_value", inc_dec_value, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        @(posedge wclk); #1 wrst_n = 1'b1;
        cyc(1);

        // 1: 3-word good packet
        snap();
        word(64'hA1, 1, 0, 0);
        word(64'hA2, 0, 0, 0);
        word(64'hA3, 0, 1, 0);
        @(negedge wclk);
        check("t1_inc_pulse", inc_wptr, 1);
        check("t1_value", inc_dec_value, 3);
        check("t1_ready_commit", in_ready, 0);
        cyc(1);
        @(negedge wclk);
        check("t1_winc_count", n_winc - b_winc, 3);
        check("t1_inc_count", n_inc - b_inc, 1);
        check("t1_pkt_cnt", pkt_cnt, 1);
        check("t1_inc_idle", inc_wptr, 0);
        drain();

        // 2: 4-word packet aborted on eop
        snap();
        word(64'hB1, 1, 0, 0);
        word(64'hB2, 0, 0, 0);
        word(64'hB3, 0, 0, 0);
        word(64'hB4, 0, 1, 1);
        @(negedge wclk);
        check("t2_dec_pulse", dec_wptr, 1);
        check("t2_value", inc_dec_value, 4);
        cyc(2);
        check("t2_winc_count", n_winc - b_winc, 4);
        check("t2_inc_never", n_inc - b_inc, 0);
        check("t2_drop_cnt", drop_cnt, 1);
        check("t2_occ", occ, 0);

        // 3: 20-word packet overflows an empty FIFO
        snap();
        for (int i = 0; i < 20; i++)
            word(64'h300 + 64'(i), (i == 0), (i == 19), 0);
        @(negedge wclk);
        check("t3_ready_idle", in_ready, 1);
        check("t3_winc_count", n_winc - b_winc, 16);
        check("t3_dec_count", n_dec - b_dec, 1);
        check("t3_dec_value", last_dec_val, 16);
        check("t3_dropped_words", n_skip - b_skip, 4);
        check("t3_drop_cnt", drop_cnt, 2);
        check("t3_pkt_cnt", pkt_cnt, 1);
        cyc(1);

        // 4: 14 committed words unread, then a 5-word packet stalls on full
        for (int i = 0; i < 14; i++)
            word(64'h400 + 64'(i), (i == 0), (i == 13), 0);
        cyc(2);
        check("t4_occ_14", occ, 14);
        snap();
        word(64'h4A0, 1, 0, 0);
        word(64'h4A1, 0, 0, 0);
        in_valid = 1'b1; in_data = 64'h4A2;
        repeat (3) begin
            @(negedge wclk);
            check("t4_stall_ready", in_ready, 0);
            check("t4_stall_winc", winc, 0);
            @(posedge wclk); #1;
        end
        in_valid = 1'b0;
        rd = 1'b1; cyc(3); rd = 1'b0;
        word(64'h4A2, 0, 0, 0);
        word(64'h4A3, 0, 0, 0);
        word(64'h4A4, 0, 1, 0);
        @(negedge wclk);
        check("t4_inc_pulse", inc_wptr, 1);
        check("t4_value", inc_dec_value, 5);
        check("t4_winc_count", n_winc - b_winc, 5);
        for (int i = 0; i < 5; i++)
            check("t4_data_order", wq[wq.size() - 5 + i], 64'h4A0 + 64'(i));
        cyc(1);
        check("t4_pkt_cnt", pkt_cnt, 3);
        drain();

        // 5: sop arrives after 2 words of a packet
        snap();
        word(64'h51, 1, 0, 0);
        word(64'h52, 0, 0, 0);
        in_valid = 1'b1; in_data = 64'h5B0; in_sop = 1'b1;
        @(negedge wclk);
        check("t5_ready_sop", in_ready, 0);
        @(posedge wclk); #1;
        @(negedge wclk);
        check("t5_dec_pulse", dec_wptr, 1);
        check("t5_dec_value", inc_dec_value, 2);
        @(posedge wclk); #1;
        word(64'h5B0, 1, 0, 0);
        word(64'h5B1, 0, 1, 0);
        cyc(1);
        check("t5_inc_value", last_inc_val, 2);
        check("t5_pkt_cnt", pkt_cnt, 4);
        check("t5_drop_cnt", drop_cnt, 3);
        check("t5_winc_count", n_winc - b_winc, 4);
        drain();

        // Non-sop word in IDLE is discarded
        snap();
        word(64'hEE, 0, 0, 0);
        @(negedge wclk);
        check("idle_discard_winc", n_winc - b_winc, 0);
        check("idle_discard_drop", drop_cnt, 4);
        cyc(1);

        // 6: async reset mid-packet
        for (int i = 0; i < 5; i++)
            word(64'h600 + 64'(i), (i == 0), 0, 0);
        #2 wrst_n = 1'b0;
        #1;
        check("t6_rst_winc", winc, 0);
        check("t6_rst_inc", inc_wptr, 0);
        check("t6_rst_dec", dec_wptr, 0);
        check("t6_rst_value", inc_dec_value, 0);
        check("t6_rst_pkt_cnt", pkt_cnt, 0);
        check("t6_rst_drop_cnt", drop_cnt, 0);
        @(posedge wclk); #1 wrst_n = 1'b1;
        word(64'h6F, 1, 1, 0);
        @(negedge wclk);
        check("t6_inc_pulse", inc_wptr, 1);
        check("t6_value", inc_dec_value, 1);
        cyc(1);
        check("t6_pkt_cnt", pkt_cnt, 1);
        check("t6_drop_cnt", drop_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
